// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
// Turns a stream of PS/2 set-2 scan-code bytes into key make/break events,
// keeps a 512-entry held-key bitmap and flags malformed or stalled prefixes.
// Optional feature macro: KEY_REPEAT_FILTER_EN -- when defined, typematic
// repeats (make of an already-held key, break of an already-released key)
// do not produce key_valid.
//
// Handshake: rx_valid is a single-cycle strobe with no back-pressure; each
// cycle it is high, rx_byte is consumed. key_valid and seq_err are
// single-cycle output strobes with no ready; key_code/key_make hold their
// value between key_valid pulses.
module ps2_key_event_decoder #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [8:0]   key_code,
  output logic         key_make,
  output logic         key_valid,
  output logic [511:0] key_down,
  output logic         any_key,
  output logic         seq_err,
  output logic [1:0]   dbg_state_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  // The idle counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       key_code_q, key_code_d;
  logic             key_make_q, key_make_d;
  logic             key_valid_q, key_valid_d;
  logic [511:0]     key_down_q, key_down_d;
  logic             any_key_q;
  logic             seq_err_q, seq_err_d;

  logic             emit;
  logic             emit_make;
  logic [8:0]       emit_code;
  logic             emit_ok;
  logic             timeout_hit;
  logic             byte_ignored;
  logic             byte_prefix;

  assign timeout_hit  = (state_q != IDLE) && (cnt_q == CNT_LAST);
  assign byte_prefix  = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
  assign byte_ignored = (rx_byte == 8'h00) || (rx_byte == 8'hAA) ||
                        (rx_byte == 8'hE1) || (rx_byte == 8'hFA) ||
                        (rx_byte == 8'hFE) || (rx_byte == 8'hFF);

  // Prefix FSM: decide next state, whether an event completes, and errors.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_make = 1'b0;
    emit_code = 9'd0;
    seq_err_d = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_byte == 8'hE0) begin
            state_d = EXT;
          end else if (rx_byte == 8'hF0) begin
            state_d = BRK;
          end else if (!byte_ignored) begin
            emit      = 1'b1;
            emit_make = 1'b1;
            emit_code = {1'b0, rx_byte};
          end
        end
        EXT: begin
          if (rx_byte == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (rx_byte != 8'hE0) begin
            emit      = 1'b1;
            emit_make = 1'b1;
            emit_code = {1'b1, rx_byte};
            state_d   = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (byte_prefix) begin
            seq_err_d = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_code = {1'b0, rx_byte};
          end
        end
        default: begin
          state_d = IDLE;
          if (byte_prefix) begin
            seq_err_d = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_code = {1'b1, rx_byte};
          end
        end
      endcase
    end else if (timeout_hit) begin
      // A stalled prefix is dropped; a byte in the same cycle wins instead.
      state_d   = IDLE;
      seq_err_d = 1'b1;
    end
  end

  // Idle-cycle counter: runs only mid-sequence, restarts on any byte.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (rx_valid || (state_q == IDLE) || timeout_hit) begin
      cnt_d = '0;
    end
  end

  // Repeat filter: with the feature on, only state-changing events are announced.
  always_comb begin
`ifdef KEY_REPEAT_FILTER_EN
    emit_ok = emit && (emit_make ? !key_down_q[emit_code] : key_down_q[emit_code]);
`else
    emit_ok = emit;
`endif
  end

  // Event registers and held-key bitmap update.
  always_comb begin
    key_code_d  = key_code_q;
    key_make_d  = key_make_q;
    key_valid_d = emit_ok;
    key_down_d  = key_down_q;
    if (emit_ok) begin
      key_code_d             = emit_code;
      key_make_d             = emit_make;
      key_down_d[emit_code]  = emit_make;
    end
  end

  // State and output registers; reset also discards any partial sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_code_q  <= 9'd0;
      key_make_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_down_q  <= '0;
      any_key_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_make_q  <= key_make_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      any_key_q   <= |key_down_q;
      seq_err_q   <= seq_err_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_make    = key_make_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign any_key     = any_key_q;
  assign seq_err     = seq_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder (TIMEOUT_CYCLES = 16).
// Build with or without KEY_REPEAT_FILTER_EN; repeat expectations follow it.
module tb_ps2_key_event_decoder;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_BRK  = 2'd2;

  logic         clk;
  logic         rst;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic [8:0]   key_code;
  logic         key_make;
  logic         key_valid;
  logic [511:0] key_down;
  logic         any_key;
  logic         seq_err;
  logic [1:0]   dbg_state;

  int tests;
  int fails;

  // Expected events: {make, code}
  logic [9:0] exp_q[$];

  ps2_key_event_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .key_code    (key_code),
    .key_make    (key_make),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .any_key     (any_key),
    .seq_err     (seq_err),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one byte per cycle, returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every key_valid pulse must match the head of exp_q.
  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_key_valid", {502'd0, key_make, key_code}, 512'h3ff);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("event", {502'd0, key_make, key_code}, {502'd0, e});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tests    = 0;
    fails    = 0;

    // Reset state
    idle_cycles(2);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_key_code", key_code, 0);
    chk("rst_key_make", key_make, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_any_key", any_key, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_state", dbg_state, S_IDLE);

    // Plain make 70, then break F0 70
    exp_q.push_back({1'b1, 9'h070});
    send(8'h70);
    chk("mk70_valid", key_valid, 1);
    chk("mk70_code", key_code, 9'h070);
    chk("mk70_make", key_make, 1);
    chk("mk70_down", key_down[112], 1);
    chk("mk70_any_lag", any_key, 0);
    idle_cycles(1);
    chk("mk70_valid_pulse", key_valid, 0);
    chk("mk70_any", any_key, 1);
    chk("mk70_hold_code", key_code, 9'h070);
    send(8'hF0);
    chk("f0_state", dbg_state, S_BRK);
    chk("f0_no_valid", key_valid, 0);
    exp_q.push_back({1'b0, 9'h070});
    send(8'h70);
    chk("brk70_valid", key_valid, 1);
    chk("brk70_make", key_make, 0);
    chk("brk70_down", key_down[112], 0);
    idle_cycles(2);
    chk("brk70_any", any_key, 0);

    // Extended make/break of 9'h170
    exp_q.push_back({1'b1, 9'h170});
    send(8'hE0);
    chk("e0_state", dbg_state, S_EXT);
    send(8'h70);
    chk("mk170_code", key_code, 9'h170);
    chk("mk170_down", key_down[368], 1);
    chk("mk170_kp0", key_down[112], 0);
    exp_q.push_back({1'b0, 9'h170});
    send(8'hE0);
    send(8'hF0);
    send(8'h70);
    chk("brk170_make", key_make, 0);
    chk("brk170_down", key_down[368], 0);
    chk("brk170_kp0", key_down[112], 0);

    // Typematic repeat of 69, back to back
`ifdef KEY_REPEAT_FILTER_EN
    exp_q.push_back({1'b1, 9'h069});
`else
    exp_q.push_back({1'b1, 9'h069});
    exp_q.push_back({1'b1, 9'h069});
    exp_q.push_back({1'b1, 9'h069});
`endif
    send(8'h69);
    send(8'h69);
    send(8'h69);
    idle_cycles(1);
    chk("rep69_drained", exp_q.size(), 0);
    chk("rep69_down", key_down[105], 1);
    exp_q.push_back({1'b0, 9'h069});
    send(8'hF0);
    send(8'h69);
    chk("rel69_down", key_down[105], 0);

    // Timeout after E0: seq_err on the 16th idle edge
    send(8'hE0);
    idle_cycles(15);
    chk("to_early_err", seq_err, 0);
    chk("to_early_state", dbg_state, S_EXT);
    idle_cycles(1);
    chk("to_err", seq_err, 1);
    chk("to_state", dbg_state, S_IDLE);
    idle_cycles(1);
    chk("to_err_pulse", seq_err, 0);
    exp_q.push_back({1'b1, 9'h072});
    send(8'h72);
    chk("to_mk72_code", key_code, 9'h072);

    // Byte arriving on the timeout cycle wins
    send(8'hE0);
    idle_cycles(15);
    exp_q.push_back({1'b1, 9'h174});
    send(8'h74);
    chk("prio_no_err", seq_err, 0);
    chk("prio_code", key_code, 9'h174);
    chk("prio_state", dbg_state, S_IDLE);

    // Protocol error F0 E0, then recovery
    send(8'hF0);
    send(8'hE0);
    chk("perr_err", seq_err, 1);
    chk("perr_no_valid", key_valid, 0);
    chk("perr_state", dbg_state, S_IDLE);
    exp_q.push_back({1'b1, 9'h07A});
    send(8'h7A);
    chk("perr_mk7a_code", key_code, 9'h07A);
    chk("perr_mk7a_make", key_make, 1);

    // Ignored byte in IDLE
    send(8'hAA);
    chk("ign_aa_valid", key_valid, 0);
    chk("ign_aa_code", key_code, 9'h07A);

    // Reset with keys held, mid-sequence, with a byte in the reset cycle
    exp_q.push_back({1'b1, 9'h070});
    send(8'h70);
    idle_cycles(1);
    chk("pre_rst_any", any_key, 1);
    send(8'hE0);
    @(negedge clk);
    rst      = 1'b1;
    rx_byte  = 8'h15;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk("rst2_down", key_down, 0);
    chk("rst2_any", any_key, 0);
    chk("rst2_valid", key_valid, 0);
    chk("rst2_state", dbg_state, S_IDLE);
    idle_cycles(3);
    chk("rst2_any_after", any_key, 0);
    chk("rst2_valid_after", key_valid, 0);
    exp_q.push_back({1'b1, 9'h070});
    send(8'h70);
    chk("rst2_mk_code", key_code, 9'h070);

    idle_cycles(2);
    chk("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_decoder.md
PS2_KEY_EVENT_DECODER -- requirements
Module: ps2_key_event_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, the idle cycles after which a partial prefix sequence is abandoned.
REQ-002 SHALL have port clk  input  1  system clock; all logic rises on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_byte  input  8  scan-code byte from the upstream PS/2 byte receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_byte.
REQ-006 SHALL have port key_code  output  9  last completed code: bit8 = E0-extended, bits7:0 = scan code (keypad 0 = 9'h070, Insert = 9'h170).
REQ-007 SHALL have port key_make  output  1  qualifier of key_code: 1 = press, 0 = release.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse announcing a new key_code/key_make.
REQ-009 SHALL have port key_down  output  512  held-key bitmap indexed by the 9-bit code.
REQ-010 SHALL have port any_key  output  1  OR-reduction of key_down, registered.
REQ-011 SHALL have port seq_err  output  1  one-cycle pulse on protocol error or timeout.

Function
REQ-012 SHALL implement FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); a state changes only on rx_valid or timeout.
REQ-013 SHALL, in IDLE: on E0 go to EXT; on F0 go to BRK; on 00, AA, E1, FA, FE or FF ignore the byte and stay in IDLE; on any other byte emit make {0,byte} and stay in IDLE.
REQ-014 SHALL, in EXT: on F0 go to EXT_BRK; on E0 stay in EXT; on any other byte emit make {1,byte} and go to IDLE.
REQ-015 SHALL, in BRK: on any byte other than E0 or F0 emit break {0,byte}; on E0 or F0 pulse seq_err and emit nothing; in every case go to IDLE.
REQ-016 SHALL, in EXT_BRK: on any byte other than E0 or F0 emit break {1,byte}; on E0 or F0 pulse seq_err and emit nothing; in every case go to IDLE.
REQ-017 SHALL "emit" by registering key_code and key_make and pulsing key_valid for one cycle, on the cycle after the rx_valid of the final byte (latency 1).
REQ-018 SHALL update key_down in the same cycle as key_valid: a make sets the bit, a break clears it; any_key follows one cycle later.
REQ-019 SHALL hold key_code and key_make between events.
REQ-020 SHALL count cycles without rx_valid while the state is not IDLE; when the count reaches TIMEOUT_CYCLES, it SHALL go to IDLE and pulse seq_err; the counter SHALL restart on every rx_valid.
REQ-021 SHALL give rx_valid priority over a timeout occurring in the same cycle: the byte is processed in the current state and no seq_err is raised.
REQ-022 SHALL process back-to-back rx_valid on consecutive cycles without loss.

Reset
REQ-023 SHALL, with rst high at a clock edge, set the state to IDLE, clear the timeout counter, and set key_code=0, key_make=0, key_valid=0, key_down=0, any_key=0 and seq_err=0.
REQ-024 SHALL discard a partial sequence if reset occurs mid-sequence; a byte with rx_valid in the reset cycle is ignored.

Configuration
REQ-025 SHALL, when KEY_REPEAT_FILTER_EN is defined: suppress key_valid for a make whose key_down bit is already set, and for a break whose bit is already clear; key_down stays unchanged.
REQ-026 SHALL, without KEY_REPEAT_FILTER_EN: emit key_valid for every completed make or break, including typematic repeats.

Verification
REQ-027 SHALL cover: bytes 70, then F0 70 -> key_valid with 9'h070, make=1 and key_down[112]=1; then key_valid with 9'h070, make=0 and key_down[112]=0.
REQ-028 SHALL cover: bytes E0 70, then E0 F0 70 -> make and break of 9'h170; key_down[368] set then cleared; key_down[112] untouched.
REQ-029 SHALL cover: byte 69 sent three times with the macro defined -> one key_valid; without the macro -> three key_valid pulses.
REQ-030 SHALL cover: byte E0, then no byte for TIMEOUT_CYCLES (set to 16) -> seq_err pulse at cycle 16; a following 72 gives make 9'h072.
REQ-031 SHALL cover: bytes F0 E0 -> seq_err, no key_valid, state returns to IDLE; a following 7A gives make 9'h07A.
REQ-032 SHALL cover: keys 70 and 72 held, rst asserted for one cycle -> key_down=0, any_key=0, and no key_valid during or after reset.
